// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle for uart_tx_fifo: oversampling tick, write port, per-frame config,
// serial line and status. master = host/bench, slave = transmitter.
interface uart_tx_fifo_if #(
  parameter int unsigned DBIT = 8
);
  logic            i_s_tick;
  logic            i_wr;
  logic [DBIT-1:0] i_din;
  logic            i_parity_en;
  logic            i_parity_odd;
  logic            i_two_stop;
  logic            o_tx;
  logic            o_tx_done_tick;
  logic            o_busy;
  logic            o_full;
  logic            o_empty;

  modport master (
    output i_s_tick, i_wr, i_din, i_parity_en, i_parity_odd, i_two_stop,
    input  o_tx, o_tx_done_tick, o_busy, o_full, o_empty
  );

  modport slave (
    input  i_s_tick, i_wr, i_din, i_parity_en, i_parity_odd, i_two_stop,
    output o_tx, o_tx_done_tick, o_busy, o_full, o_empty
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO. Words leave LSB-first, framed by a start bit,
// optional parity and one or two stop bits. Config is latched per frame when the word is popped.
module uart_tx_fifo #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  uart_tx_fifo_if.slave   bus
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned SW    = $clog2(2 * OVERSAMPLE);
  localparam int unsigned NW    = $clog2(DBIT);

  localparam logic [SW-1:0] SLastOne = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SLastTwo = SW'(2 * OVERSAMPLE - 1);
  localparam logic [NW-1:0] NLast    = NW'(DBIT - 1);
  localparam logic [CW-1:0] CntFull  = CW'(Depth);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [DBIT-1:0]    mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               full_q, empty_q;
  logic               push, pop;
  logic [DBIT-1:0]    head;

  // Transmit FSM state
  state_e          state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] shift_q;
  logic            par_bit_q, par_en_q, two_stop_q;
  logic            tx_q, done_q;
  logic [SW-1:0]   stop_last;
  logic            stop_end;

  assign head      = mem_q[rd_ptr_q];
  assign push      = bus.i_wr & ~full_q;
  assign stop_last = two_stop_q ? SLastTwo : SLastOne;
  assign stop_end  = (state_q == StStop) && bus.i_s_tick && (s_q == stop_last);
  // Pop either from IDLE or on the final stop tick so back-to-back frames have no gap.
  assign pop       = ~empty_q & ((state_q == StIdle) | stop_end);

  // Next occupancy; a push and a pop in the same cycle cancel out
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and registered full/empty flags
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CntFull);
      empty_q <= (count_d == '0);
    end
  end

  // FIFO data array; contents need no reset since the pointers guard them
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_din;
  end

  // Frame sequencer; tx_q is loaded with the next-state line value
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      s_q        <= '0;
      n_q        <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (!empty_q) begin
            shift_q    <= head;
            par_bit_q  <= (^head) ^ bus.i_parity_odd;
            par_en_q   <= bus.i_parity_en;
            two_stop_q <= bus.i_two_stop;
            s_q        <= '0;
            n_q        <= '0;
            state_q    <= StStart;
            tx_q       <= 1'b0;
          end
        end
        StStart: begin
          if (bus.i_s_tick) begin
            if (s_q == SLastOne) begin
              s_q     <= '0;
              n_q     <= '0;
              state_q <= StData;
              tx_q    <= shift_q[0];
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        StData: begin
          if (bus.i_s_tick) begin
            if (s_q == SLastOne) begin
              s_q     <= '0;
              shift_q <= shift_q >> 1;
              if (n_q == NLast) begin
                if (par_en_q) begin
                  state_q <= StParity;
                  tx_q    <= par_bit_q;
                end else begin
                  state_q <= StStop;
                  tx_q    <= 1'b1;
                end
              end else begin
                n_q  <= n_q + NW'(1);
                tx_q <= shift_q[1];
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        StParity: begin
          if (bus.i_s_tick) begin
            if (s_q == SLastOne) begin
              s_q     <= '0;
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        StStop: begin
          if (bus.i_s_tick) begin
            if (s_q == stop_last) begin
              done_q <= 1'b1;
              s_q    <= '0;
              if (!empty_q) begin
                shift_q    <= head;
                par_bit_q  <= (^head) ^ bus.i_parity_odd;
                par_en_q   <= bus.i_parity_en;
                two_stop_q <= bus.i_two_stop;
                n_q        <= '0;
                state_q    <= StStart;
                tx_q       <= 1'b0;
              end else begin
                state_q <= StIdle;
                tx_q    <= 1'b1;
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_tx           = tx_q;
  assign bus.o_tx_done_tick = done_q;
  assign bus.o_busy         = (state_q != StIdle);
  assign bus.o_full         = full_q;
  assign bus.o_empty        = empty_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed steps push expected frames to a queue; a line monitor
// decodes each frame from o_tx by counting ticks and compares it with the queue head.
module tb_uart_tx_fifo;
  localparam int unsigned DBIT = 8;
  localparam int unsigned OS   = 16;
  localparam int unsigned AW   = 2;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       po;
    logic       ts;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   frames = 0;
  int   done_count = 0;
  exp_t exp_q[$];
  logic done_tx_q[$];

  uart_tx_fifo_if #(.DBIT(DBIT)) bus ();

  uart_tx_fifo #(
    .DBIT      (DBIT),
    .OVERSAMPLE(OS),
    .FIFO_AW   (AW)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_tx_done_tick === 1'b1) done_count <= done_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic po, input logic ts);
    exp_t e;
    e.data = d;
    e.pe   = pe;
    e.po   = po;
    e.ts   = ts;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      step(1);
      n++;
    end
    check("wait_frames", 32'(frames >= target), 32'(1));
  endtask

  // Line monitor: decodes one frame per falling start edge
  initial begin : monitor
    exp_t        e;
    int          ticks;
    int          clocks;
    int          total;
    logic [15:0] bits;
    logic [7:0]  data;
    logic        t;
    bit          aborted;
    forever begin
      while (bus.o_tx !== 1'b0 || rst === 1'b1) @(negedge clk);
      check("frame_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() == 0) begin
        while (bus.o_tx === 1'b0) @(negedge clk);
        continue;
      end
      e       = exp_q.pop_front();
      total   = OS * (1 + DBIT + int'(e.pe) + (e.ts ? 2 : 1));
      ticks   = 0;
      clocks  = 0;
      bits    = '0;
      aborted = 1'b0;
      forever begin
        @(posedge clk);
        t = bus.i_s_tick;
        @(negedge clk);
        clocks++;
        if (rst === 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (t === 1'b1) begin
          ticks++;
          if (ticks % OS == OS / 2) bits[ticks / OS] = bus.o_tx;
        end
        if (bus.o_tx_done_tick === 1'b1) break;
        if (ticks > total || clocks > 5000) break;
      end
      if (!aborted) begin
        check("frame_ticks", 32'(ticks), 32'(total));
        check("start_bit", 32'(bits[0]), 32'(0));
        for (int i = 0; i < DBIT; i++) data[i] = bits[1 + i];
        check("data_bits", 32'(data), 32'(e.data));
        if (e.pe) check("parity_bit", 32'(bits[1 + DBIT]), 32'((^e.data) ^ e.po));
        check("stop_bit1", 32'(bits[1 + DBIT + int'(e.pe)]), 32'(1));
        if (e.ts) check("stop_bit2", 32'(bits[2 + DBIT + int'(e.pe)]), 32'(1));
        done_tx_q.push_back(bus.o_tx);
        frames++;
      end
    end
  end

  initial begin : stim
    int         f0;
    int         d0;
    int         lows;
    logic [7:0] d;
    bus.i_s_tick     = 1'b1;
    bus.i_wr         = 1'b0;
    bus.i_din        = '0;
    bus.i_parity_en  = 1'b0;
    bus.i_parity_odd = 1'b0;
    bus.i_two_stop   = 1'b0;
    step(3);
    check("rst_tx", 32'(bus.o_tx), 32'(1));
    check("rst_done", 32'(bus.o_tx_done_tick), 32'(0));
    check("rst_busy", 32'(bus.o_busy), 32'(0));
    check("rst_full", 32'(bus.o_full), 32'(0));
    check("rst_empty", 32'(bus.o_empty), 32'(1));
    rst = 1'b0;
    step(2);

    // Single 0xA5, no parity, one stop; check E0/E1 latency
    bus.i_din = 8'hA5;
    bus.i_wr  = 1'b1;
    push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
    step(1);
    bus.i_wr = 1'b0;
    check("e0_empty", 32'(bus.o_empty), 32'(0));
    check("e0_busy", 32'(bus.o_busy), 32'(0));
    check("e0_tx", 32'(bus.o_tx), 32'(1));
    step(1);
    check("e1_empty", 32'(bus.o_empty), 32'(1));
    check("e1_busy", 32'(bus.o_busy), 32'(1));
    check("e1_tx", 32'(bus.o_tx), 32'(0));
    wait_frames(1, 400);
    step(1);
    check("t1_busy_low", 32'(bus.o_busy), 32'(0));
    check("t1_done_count", 32'(done_count), 32'(1));

    // Even then odd parity, two stops
    bus.i_parity_en = 1'b1;
    bus.i_two_stop  = 1'b1;
    bus.i_din       = 8'hA5;
    bus.i_wr        = 1'b1;
    push_exp(8'hA5, 1'b1, 1'b0, 1'b1);
    step(1);
    bus.i_wr = 1'b0;
    wait_frames(2, 400);
    step(2);
    bus.i_parity_odd = 1'b1;
    bus.i_wr         = 1'b1;
    push_exp(8'hA5, 1'b1, 1'b1, 1'b1);
    step(1);
    bus.i_wr = 1'b0;
    wait_frames(3, 400);
    step(2);

    // Six consecutive writes: fifth fills the FIFO, sixth is dropped
    bus.i_parity_en  = 1'b0;
    bus.i_parity_odd = 1'b0;
    bus.i_two_stop   = 1'b0;
    done_tx_q.delete();
    f0 = frames;
    d0 = done_count;
    for (int i = 1; i <= 6; i++) begin
      bus.i_din = 8'(i);
      bus.i_wr  = 1'b1;
      if (i <= 5) push_exp(8'(i), 1'b0, 1'b0, 1'b0);
      step(1);
      if (i == 4) check("full_after_4", 32'(bus.o_full), 32'(0));
      if (i >= 5) check("full_after_5plus", 32'(bus.o_full), 32'(1));
    end
    bus.i_wr = 1'b0;
    wait_frames(f0 + 5, 1500);
    step(40);
    check("burst_frames", 32'(frames), 32'(f0 + 5));
    check("burst_done_pulses", 32'(done_count), 32'(d0 + 5));
    check("burst_done_tx_n", 32'(done_tx_q.size()), 32'(5));
    for (int i = 0; i < done_tx_q.size(); i++)
      check("burst_gapless", 32'(done_tx_q[i]), 32'((i < 4) ? 0 : 1));

    // Config change mid-frame only affects the following frame
    bus.i_parity_en = 1'b1;
    f0 = frames;
    bus.i_din = 8'h5A;
    bus.i_wr  = 1'b1;
    push_exp(8'h5A, 1'b1, 1'b0, 1'b0);
    step(1);
    bus.i_din = 8'hC3;
    push_exp(8'hC3, 1'b1, 1'b1, 1'b1);
    step(1);
    bus.i_wr = 1'b0;
    step(30);
    bus.i_parity_odd = 1'b1;
    bus.i_two_stop   = 1'b1;
    wait_frames(f0 + 2, 800);
    bus.i_parity_en  = 1'b0;
    bus.i_parity_odd = 1'b0;
    bus.i_two_stop   = 1'b0;
    step(4);

    // Tick held low during DATA: line freezes mid data bit 2
    f0 = frames;
    d = 8'h3C;
    bus.i_din = d;
    bus.i_wr  = 1'b1;
    push_exp(d, 1'b0, 1'b0, 1'b0);
    step(1);
    bus.i_wr = 1'b0;
    step(1);
    step(56);
    bus.i_s_tick = 1'b0;
    check("hold_tx_before", 32'(bus.o_tx), 32'(d[2]));
    step(100);
    check("hold_tx_after", 32'(bus.o_tx), 32'(d[2]));
    check("hold_busy", 32'(bus.o_busy), 32'(1));
    check("hold_empty", 32'(bus.o_empty), 32'(1));
    bus.i_s_tick = 1'b1;
    wait_frames(f0 + 1, 400);
    step(4);

    // Reset mid-DATA with three words queued
    for (int i = 0; i < 4; i++) begin
      bus.i_din = 8'(8'h11 + i);
      bus.i_wr  = 1'b1;
      push_exp(8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
      step(1);
    end
    bus.i_wr = 1'b0;
    step(50);
    check("pre_rst_busy", 32'(bus.o_busy), 32'(1));
    rst = 1'b1;
    #1;
    check("rst_mid_tx", 32'(bus.o_tx), 32'(1));
    check("rst_mid_empty", 32'(bus.o_empty), 32'(1));
    check("rst_mid_busy", 32'(bus.o_busy), 32'(0));
    check("rst_mid_full", 32'(bus.o_full), 32'(0));
    exp_q.delete();
    f0 = frames;
    d0 = done_count;
    step(1);
    rst  = 1'b0;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (bus.o_tx !== 1'b1) lows++;
    end
    check("post_rst_line_idle", 32'(lows), 32'(0));
    check("post_rst_frames", 32'(frames), 32'(f0));
    check("post_rst_done", 32'(done_count), 32'(d0));
    check("post_rst_busy", 32'(bus.o_busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO and per-frame selectable parity and stop-bit count. It serialises DBIT-wide words LSB-first onto o_tx, timed by an external oversampling tick (i_s_tick, OVERSAMPLE ticks per bit), and sits between the host-side write logic and the board TX pin. Queued words go out back-to-back with no idle gap.

## Interface
- DBIT, 8: data bits per frame, legal 5..8.
- OVERSAMPLE, 16: i_s_tick pulses per bit period, legal 8..16.
- FIFO_AW, 2: FIFO address width; depth = 2**FIFO_AW.
- i_clk  in  1  system clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_s_tick  in  1  one-clock oversampling strobe from the baud generator.
- i_wr  in  1  write strobe; pushes i_din when o_full=0.
- i_din  in  DBIT  word to transmit.
- i_parity_en  in  1  1 = append parity bit.
- i_parity_odd  in  1  1 = odd parity, 0 = even; ignored when i_parity_en=0.
- i_two_stop  in  1  1 = two stop bits, 0 = one.
- o_tx  out  1  serial line, registered, idle high.
- o_tx_done_tick  out  1  registered one-clock pulse at end of each frame.
- o_busy  out  1  high whenever FSM is not IDLE.
- o_full  out  1  FIFO full.
- o_empty  out  1  FIFO empty.

## Operation
- Reset values: o_tx=1, o_tx_done_tick=0, o_busy=0, o_full=0, o_empty=1; FSM IDLE, FIFO pointers and count 0.
- FIFO: write accepted when i_wr=1 and o_full=0 (registered flag at that edge); write while full is dropped silently, no state change. No bypass: a word written into an empty FIFO is visible to the FSM one clock later.
- Simultaneous push and pop: both occur; count unchanged. When full, push is dropped even if pop occurs in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_tx=1. When o_empty=0: pop head into shift register, latch i_parity_en, i_parity_odd and i_two_stop, clear tick counter s and bit counter n, go to START. Config is sampled only at this point; changes mid-frame have no effect.
- START: o_tx=0. Each i_s_tick increments s; on tick with s=OVERSAMPLE-1, clear s, n=0, go to DATA.
- DATA: o_tx=shift[0]. On tick with s=OVERSAMPLE-1, clear s, shift right; if n=DBIT-1, go to PARITY if parity latched, else STOP; otherwise n+1.
- PARITY: o_tx = XOR of the frame's DBIT data bits, inverted if odd; lasts OVERSAMPLE ticks, then STOP.
- STOP: o_tx=1; lasts OVERSAMPLE ticks (one stop) or 2*OVERSAMPLE ticks (two stop). s is wide enough for 2*OVERSAMPLE-1. On the final tick, pulse o_tx_done_tick. If the FIFO is non-empty, pop and go straight to START, re-sampling config. Otherwise go to IDLE.
- Ticks outside a frame are ignored. With i_s_tick held low, the FSM holds its state and o_tx holds its level indefinitely.
- o_tx is driven from a register loaded with the next-state line value, so the line changes on the same edge as the state transition.

## Timing
- Write accepted at edge E0 into an empty FIFO, with FSM IDLE: o_empty falls after E0. At E1 the FSM enters START, o_tx falls and o_empty rises again.
- Each bit lasts exactly OVERSAMPLE ticks. The boundary falls on the clock edge that samples the OVERSAMPLE-th tick.
- Frame length in ticks = OVERSAMPLE*(1+DBIT+parity+stop count).
- o_tx_done_tick is high for exactly the one clock after the edge that samples the final stop tick.
- Back-to-back frames: the next start bit begins on that same edge, with zero idle clocks.
- Reset asserted mid-frame: o_tx returns to 1 immediately (asynchronous), FIFO contents are discarded, and no o_tx_done_tick is produced.

## Test plan
- DBIT=8, OVERSAMPLE=16, i_s_tick every clock, no parity, one stop; write 0xA5 -> o_tx runs 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks; o_tx_done_tick pulses 160 clocks after o_tx falls; o_busy falls.
- Same word, parity even, then parity odd, each with two stops -> parity bit 0 (even), then 1 (odd); stop high for 32 ticks; frame 192 ticks.
- FIFO_AW=2, six i_wr on consecutive clocks with 0x01..0x06 while idle -> o_full asserts after fifth write; 0x01..0x05 transmitted back-to-back with no idle gaps; 0x06 never appears; five done pulses.
- Toggle i_parity_odd and i_two_stop during the first of two queued frames -> first frame uses the config latched at its start; second frame uses the new config.
- i_s_tick held low for 100 clocks during DATA -> o_tx and state unchanged; transmission resumes correctly when ticks restart.
- Assert i_reset mid-DATA with 3 words queued -> o_tx=1, o_empty=1, o_busy=0 immediately; after release, line stays idle with no output.
